// File: rtl/face_matrix_sequencer.sv
// MAX7219 8x8 face sequencer: sends the init words after reset, then writes the
// 8 rows of the selected face. Rewrites the frame on a face change or on a refresh timeout.
module face_matrix_sequencer #(
  parameter logic [3:0] INTENSITY      = 4'h8,
  parameter int         REFRESH_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  face,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [15:0] tx_word,
  output logic [4:0]  rom_addr,
  input  logic [7:0]  rom_data,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {INIT, LOAD, IDLE} state_t;

  localparam logic [25:0] REFRESH_LAST = 26'(REFRESH_CYCLES - 1);

  state_t      state;
  logic [2:0]  idx;
  logic [1:0]  shown_face;
  logic [25:0] refresh_cnt;
  logic        accept;

  function automatic logic [15:0] init_word(input logic [2:0] i);
    case (i)
      3'd0:    init_word = 16'h0900;
      3'd1:    init_word = {8'h0A, 4'h0, INTENSITY};
      3'd2:    init_word = 16'h0B07;
      3'd3:    init_word = 16'h0C01;
      default: init_word = 16'h0F00;
    endcase
  endfunction

  function automatic logic [15:0] row_word(input logic [2:0] r, input logic [7:0] bits);
    row_word = {4'h0, {1'b0, r} + 4'd1, bits};
  endfunction

  // In IDLE the ROM is pointed at row 0 of the requested face so a triggered
  // frame can present its first row in the very next cycle.
  assign rom_addr = (state == IDLE) ? {face, 3'd0} : {shown_face, idx};
  assign accept   = tx_valid && tx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= INIT;
      idx         <= 3'd0;
      shown_face  <= 2'd0;
      refresh_cnt <= 26'd0;
      tx_valid    <= 1'b0;
      tx_word     <= 16'h0000;
      busy        <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        INIT: begin
          if (accept) begin
            tx_valid <= 1'b0;
            if (idx == 3'd4) begin
              state      <= LOAD;
              idx        <= 3'd0;
              shown_face <= face;
            end else begin
              idx <= idx + 3'd1;
            end
          end else if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_word  <= init_word(idx);
          end
        end
        LOAD: begin
          if (accept) begin
            tx_valid <= 1'b0;
            if (idx == 3'd7) begin
              state      <= IDLE;
              idx        <= 3'd0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              idx <= idx + 3'd1;
            end
          end else if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_word  <= row_word(idx, rom_data);
          end
        end
        IDLE: begin
          if (face != shown_face || refresh_cnt == REFRESH_LAST) begin
            state       <= LOAD;
            busy        <= 1'b1;
            shown_face  <= face;
            refresh_cnt <= 26'd0;
            idx         <= 3'd0;
            tx_valid    <= 1'b1;
            tx_word     <= row_word(3'd0, rom_data);
          end else begin
            refresh_cnt <= refresh_cnt + 26'd1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_face_matrix_sequencer.sv
// Bench for face_matrix_sequencer: word-stream scoreboard model checked every cycle,
// directed scenarios with literal expectations, then randomized ready/face/reset traffic.
module tb_face_matrix_sequencer;

  localparam int R = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  face;
  logic        tx_ready;
  logic        tx_valid;
  logic [15:0] tx_word;
  logic [4:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        busy;
  logic        frame_done;

  logic [7:0]  rom [32];
  assign rom_data = rom[rom_addr];

  face_matrix_sequencer #(.INTENSITY(4'h8), .REFRESH_CYCLES(R)) dut (
    .clk(clk), .reset(reset), .face(face), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_word(tx_word), .rom_addr(rom_addr),
    .rom_data(rom_data), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  // Reference model: the queue of words the driver must receive, plus phase bookkeeping.
  logic [15:0] exp_q[$];
  logic [15:0] acc_log[$];
  int          m_phase;   // 0 init words, 1 frame rows, 2 idle
  int          m_left;
  int          m_cnt;
  logic [1:0]  m_face;
  logic        m_busy, m_fd, acc_prev;

  function automatic void push_rows(input logic [1:0] f);
    for (int r = 0; r < 8; r++)
      exp_q.push_back({4'h0, 4'(r + 1), rom[{f, 3'(r)}]});
  endfunction

  always @(negedge clk) begin
    logic acc;
    logic [15:0] w;
    if (reset) begin
      chk("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("reset_tx_word", {16'd0, tx_word}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd1);
      chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
      exp_q.delete();
      exp_q.push_back(16'h0900); exp_q.push_back(16'h0A08); exp_q.push_back(16'h0B07);
      exp_q.push_back(16'h0C01); exp_q.push_back(16'h0F00);
      m_phase = 0; m_left = 5; m_cnt = 0; m_face = 2'd0;
      m_busy = 1'b1; m_fd = 1'b0; acc_prev = 1'b1;
    end else begin
      acc = tx_valid && tx_ready;
      chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_busy && !acc_prev});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
      if (tx_valid) begin
        if (exp_q.size() == 0) chk("tx_word_unexpected", {16'd0, tx_word}, 32'hFFFF_FFFF);
        else chk("tx_word", {16'd0, tx_word}, {16'd0, exp_q[0]});
      end
      if (m_phase == 1) chk("rom_addr", {27'd0, rom_addr}, {27'd0, m_face, 3'(8 - m_left)});
      m_fd = 1'b0;
      if (m_phase != 2) begin
        if (acc && exp_q.size() > 0) begin
          w = exp_q.pop_front();
          acc_log.push_back(w);
          m_left--;
          if (m_left == 0) begin
            if (m_phase == 0) begin
              m_face = face; push_rows(face); m_left = 8; m_phase = 1;
            end else begin
              m_phase = 2; m_busy = 1'b0; m_fd = 1'b1; m_cnt = 0;
            end
          end
        end
      end else if (face != m_face || m_cnt == R - 1) begin
        m_face = face; push_rows(face); m_left = 8; m_phase = 1; m_busy = 1'b1; m_cnt = 0;
      end else begin
        m_cnt++;
      end
      acc_prev = acc;
    end
  end

  task automatic drive_edge();
    @(posedge clk); #1;
  endtask

  task automatic wait_fd(input string name, input int maxc);
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_done && n < maxc);
    if (!frame_done) timeout(name);
  endtask

  initial begin
    int n, t0, cnt0b07;
    reset = 1'b1; face = 2'd0; tx_ready = 1'b1;
    for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
    repeat (3) drive_edge();
    reset = 1'b0;

    // Init + first frame, with the third init word stalled for 10 cycles.
    n = 0;
    while (acc_log.size() < 2 && n < 50) begin drive_edge(); n++; end
    if (acc_log.size() < 2) timeout("first_words");
    tx_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, tx_valid}, 32'd1);
      chk("stall_word", {16'd0, tx_word}, 32'h0B07);
    end
    drive_edge();
    tx_ready = 1'b1;
    wait_fd("first_frame", 200);
    chk("frame1_len", acc_log.size(), 13);
    if (acc_log.size() >= 13) begin
      chk("w0", {16'd0, acc_log[0]}, 32'h0900);
      chk("w1", {16'd0, acc_log[1]}, 32'h0A08);
      chk("w2", {16'd0, acc_log[2]}, 32'h0B07);
      chk("w3", {16'd0, acc_log[3]}, 32'h0C01);
      chk("w4", {16'd0, acc_log[4]}, 32'h0F00);
      chk("row1_face0", {16'd0, acc_log[5]}, {16'd0, 8'h01, rom[0]});
      chk("row8_face0", {16'd0, acc_log[12]}, {16'd0, 8'h08, rom[7]});
    end
    cnt0b07 = 0;
    foreach (acc_log[i]) if (acc_log[i] == 16'h0B07) cnt0b07++;
    chk("one_0b07", cnt0b07, 1);

    // Face 0 -> 2 in IDLE.
    drive_edge();
    face = 2'd2;
    acc_log.delete();
    n = 0;
    do begin @(negedge clk); n++; end while (!busy && n < 10);
    chk("load_face2_addr", {27'd0, rom_addr}, 32'b10_000);
    wait_fd("face2_frame", 100);
    chk("face2_len", acc_log.size(), 8);
    foreach (acc_log[i]) chk("face2_row_addr", {24'd0, acc_log[i][15:8]}, i + 1);

    // Face 1 frame interrupted by a change to 3 during row 4.
    drive_edge();
    face = 2'd1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(busy && rom_addr[2:0] == 3'd4) && n < 50);
    drive_edge();
    face = 2'd3;
    wait_fd("face1_frame", 100);
    @(negedge clk);
    chk("face3_restart_valid", {31'd0, tx_valid}, 32'd1);
    chk("face3_restart_word", {16'd0, tx_word}, {16'd0, 8'h01, rom[5'd24]});

    // Periodic refresh with constant face.
    wait_fd("face3_frame", 100);
    t0 = cyc;
    wait_fd("refresh_frame", 100);
    chk("refresh_period", cyc - t0, 35);

    // Reset pulse during row 5.
    drive_edge();
    face = 2'd0;
    n = 0;
    do begin drive_edge(); n++; end while (!(busy && tx_valid && rom_addr[2:0] == 3'd5) && n < 50);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_valid", {31'd0, tx_valid}, 32'd0);
    acc_log.delete();
    drive_edge(); drive_edge();
    reset = 1'b0;
    n = 0;
    while (acc_log.size() < 1 && n < 10) begin drive_edge(); n++; end
    if (acc_log.size() < 1) timeout("restart_word");
    else chk("restart_0900", {16'd0, acc_log[0]}, 32'h0900);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      drive_edge();
      tx_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 39) == 0) face = 2'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        drive_edge(); drive_edge();
        reset = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/face_matrix_sequencer.md
# face_matrix_sequencer

Sequences the MAX7219 8x8 LED matrix that shows the pet's face. After reset it sends the driver's initialisation words, then writes all 8 rows of the face selected by the pet state. It rewrites the frame whenever the face changes, and periodically to recover from glitches. It sits between the pet state machine (face code) and the 16-bit SPI word transmitter (valid/ready handshake), and it fetches row bitmaps from an external asynchronous face ROM.

## Interface
Parameters:
- INTENSITY, 4'h8, value written to MAX7219 intensity register 0x0A
- REFRESH_CYCLES, 50_000_000, number of IDLE clk cycles before an automatic frame rewrite (1 s at 50 MHz); minimum 2

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high
- face  in  2  requested face code (0 happy, 1 hungry, 2 eating, 3 content), sampled every cycle
- tx_ready  in  1  SPI transmitter can accept a word this cycle
- tx_valid  out  1  tx_word is valid
- tx_word  out  16  MAX7219 word, {4'h0, addr[3:0], data[7:0]}, MSB sent first by transmitter
- rom_addr  out  5  {shown_face, row[2:0]} into face ROM (combinational)
- rom_data  in  8  row bitmap, combinational from rom_addr, bit 7 = leftmost column
- busy  out  1  high in INIT and LOAD
- frame_done  out  1  one-cycle pulse after the 8th row word is accepted

## Operation
- States: INIT, LOAD, IDLE. Reset enters INIT with idx=0.
- INIT sends 5 words in order: 16'h0900 (no decode), {8'h0A, 4'h0, INTENSITY}, 16'h0B07 (scan all 8 rows), 16'h0C01 (normal operation), 16'h0F00 (display test off). It then enters LOAD with row=0.
- LOAD entry latches shown_face <= face. Row r sends {4'h0, r+1, rom_data} with rom_addr = {shown_face, r}. After row 7 is accepted: frame_done=1 for one cycle, go to IDLE.
- IDLE: tx_valid=0, and the refresh counter increments. Go to LOAD (clear counter, relatch face) when face != shown_face or the counter reaches REFRESH_CYCLES-1. Both conditions in the same cycle cause a single LOAD.
- A face change during INIT or LOAD does not abort the current frame. It is detected in IDLE on the first cycle after frame_done, which starts a new LOAD.
- Handshake: tx_valid/tx_word are registered and held stable until the cycle with tx_valid && tx_ready. The next word is presented in the following cycle, so there is at most one word per 2 cycles; back-to-back acceptance is not required. tx_valid is never dropped without acceptance.
- Row data is captured into tx_word at presentation time. ROM changes while a word is pending are ignored.

## Timing
- Reset values: tx_valid=0, tx_word=16'h0000, busy=1, frame_done=0, shown_face=0, refresh counter=0, idx=0.
- First cycle after reset deasserts: tx_valid=1, tx_word=16'h0900.
- Acceptance at cycle N: tx_valid=0 at N+1, next word valid at N+1 (registered in the N edge) only if the spec allows a gap. Decided here: the next word is valid at N+2. Words are spaced at least 2 cycles apart.
- frame_done is asserted in the cycle after the row-7 acceptance, and busy falls in that same cycle.
- LOAD from IDLE: the first row word is valid 1 cycle after the trigger cycle.
- Reset asserted mid-word drops tx_valid immediately (asynchronous). The full INIT sequence restarts on release.
- Refresh counter is 26 bits wide, counts only in IDLE, and never wraps, because it is cleared on reaching REFRESH_CYCLES-1.

## Test plan
- Reset, tx_ready=1, face=0: words 0900, 0A08, 0B07, 0C01, 0F00, then 01xx..08xx using ROM face 0 rows. frame_done pulses once; busy=0 afterwards.
- tx_ready held low 10 cycles on word 3: tx_valid and tx_word=16'h0B07 are stable for all 10 cycles, and exactly one 0B07 is accepted.
- In IDLE, face 0->2: rom_addr=5'b10_000 on the next LOAD, 8 row words are sent with face-2 data, and no INIT words appear.
- face changes 1->3 during LOAD row 4: the current frame completes with face 1, then a second LOAD with face 3 starts 1 cycle after frame_done.
- REFRESH_CYCLES=20, face constant: a LOAD starts every 20 IDLE cycles with identical row words.
- Reset pulse during LOAD row 5: tx_valid=0 immediately, and the sequence restarts at 16'h0900 after release.
